// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a slow
// backing memory. Read hits complete combinationally; misses and stores go through a memory handshake.
module data_cache #(
  parameter int NBITS  = 8,
  parameter int NLINES = 8,
  parameter int CNTW   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [CNTW-1:0]  hit_cnt,
  output logic [CNTW-1:0]  miss_cnt
);
  localparam int IW = $clog2(NLINES);
  localparam int TW = NBITS - IW;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_MISS = 3'd1;
  localparam logic [2:0] RD_DONE = 3'd2;
  localparam logic [2:0] WR_THRU = 3'd3;
  localparam logic [2:0] WR_DONE = 3'd4;

  logic [2:0]       state;
  logic [NLINES-1:0] valid;
  logic [TW-1:0]    tag_arr  [NLINES];
  logic [NBITS-1:0] data_arr [NLINES];
  logic [NBITS-1:0] rdata_q;

  logic [IW-1:0] idx, m_idx;
  logic [TW-1:0] tag, m_tag;
  logic          hit;

  assign idx   = addr[IW-1:0];
  assign tag   = addr[NBITS-1:IW];
  assign m_idx = mem_addr[IW-1:0];
  assign m_tag = mem_addr[NBITS-1:IW];
  assign hit   = valid[idx] && (tag_arr[idx] == tag);

  assign mem_req = (state == RD_MISS) || (state == WR_THRU);
  assign mem_we  = (state == WR_THRU);

  always_comb begin
    busy  = 1'b0;
    rdata = '0;
    case (state)
      IDLE: begin
        busy = MemWrite || (MemRead && !hit);
        if (MemRead && !MemWrite && hit) rdata = data_arr[idx];
      end
      RD_MISS, WR_THRU: busy = 1'b1;
      RD_DONE:          rdata = rdata_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            state     <= WR_THRU;
          end else if (MemRead) begin
            if (hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
              mem_addr <= addr;
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
              state <= RD_MISS;
            end
          end
        end
        RD_MISS: if (mem_ack) begin
          valid[m_idx] <= 1'b1;
          rdata_q      <= mem_rdata;
          state        <= RD_DONE;
        end
        RD_DONE: state <= IDLE;
        WR_THRU: if (mem_ack) state <= WR_DONE;
        WR_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; gating on reset keeps a late ack from filling a line.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == IDLE && MemWrite && hit) begin
        data_arr[idx] <= wdata;
      end else if (state == RD_MISS && mem_ack) begin
        data_arr[m_idx] <= mem_rdata;
        tag_arr[m_idx]  <= m_tag;
      end
    end
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the core's load/store signals (MemRead, MemWrite, address, write data) and a slow backing data memory.
- Drives the `busy` signal the controller uses to stall PC advance.
- Hits complete in the request cycle; misses and all writes go through a handshake with backing memory.

Parameters:
- NBITS, 8, address and data width.
- NLINES, 8, number of cache lines, power of two, one NBITS-wide word per line.
- CNTW, 8, width of the hit/miss statistics counters.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- MemRead  input  1  load request; held stable by the core while busy=1.
- MemWrite  input  1  store request; held stable while busy=1.
- addr  input  NBITS  byte address of request.
- wdata  input  NBITS  store data.
- rdata  output  NBITS  load data, valid when MemRead=1 and busy=0.
- busy  output  1  request not yet complete; core must hold request.
- mem_req  output  1  backing-memory request, registered (state-decoded).
- mem_we  output  1  1=write, 0=read; meaningful while mem_req=1.
- mem_addr  output  NBITS  latched request address.
- mem_wdata  output  NBITS  latched store data.
- mem_rdata  input  NBITS  backing read data, valid with mem_ack.
- mem_ack  input  1  one-cycle completion pulse from backing memory.
- hit_cnt  output  CNTW  saturating count of read hits.
- miss_cnt  output  CNTW  saturating count of read misses.

Behaviour:
- Address split: idx = addr[$clog2(NLINES)-1:0]; tag = remaining upper bits. Per line: valid bit, tag, data. Only valid bits and counters are reset; tag/data arrays are not.
- hit = valid[idx] && tag_arr[idx]==tag, evaluated combinationally on the live addr.
- States: IDLE, RD_MISS, RD_DONE, WR_THRU, WR_DONE. Reset forces IDLE.
- IDLE, no request:
  - busy=0, rdata=0.
- IDLE, MemWrite=1 (priority over MemRead when both are high):
  - busy=1 combinationally.
  - Latch addr/wdata into mem_addr/mem_wdata.
  - If hit, update line data at the same edge; on a miss, no allocate.
  - Next state WR_THRU.
- IDLE, MemRead=1 && hit:
  - rdata=line data combinationally, busy=0.
  - hit_cnt++ at the edge. Stay IDLE.
- IDLE, MemRead=1 && miss:
  - busy=1 combinationally.
  - Latch addr into mem_addr; miss_cnt++.
  - Next state RD_MISS.
- RD_MISS:
  - mem_req=1, mem_we=0, busy=1.
  - On mem_ack: write mem_rdata into line idx of the latched addr, set tag, set valid, capture mem_rdata into rdata register. Next state RD_DONE.
- RD_DONE:
  - busy=0, rdata=captured value. Next state IDLE unconditionally.
  - No counter update and no new request accepted this cycle.
- WR_THRU:
  - mem_req=1, mem_we=1, busy=1. On mem_ack go to WR_DONE.
- WR_DONE:
  - busy=0, rdata=0. Next state IDLE.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss with ack in the k-th RD_MISS cycle (k≥1): busy high for 1+k cycles; data is returned in the following cycle.
  - Write: same timing as a read miss.
- mem_ack in IDLE/RD_DONE/WR_DONE is ignored.
- Replacement: a read miss overwrites the line unconditionally; write-through means no dirty state and no writeback.
- Counters saturate at 2^CNTW-1 and do not wrap.
- Reset mid-operation:
  - State→IDLE, all valid=0, counters=0, mem_addr/mem_wdata=0.
  - mem_req=0 from the cycle after the reset edge.
  - A late mem_ack is ignored and no line is filled.
- Reset values of outputs: rdata=0, busy=0 (with no request), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_cnt=0, miss_cnt=0.

Test Plan:
- Reset, then MemRead addr=0x05; backing memory acks with 0xA7 after 3 cycles → busy high for 4 cycles, then rdata=0xA7 with busy=0. miss_cnt=1, hit_cnt=0.
- Repeat MemRead addr=0x05 → busy=0 same cycle, rdata=0xA7, mem_req never asserted, hit_cnt=1.
- MemWrite addr=0x05 wdata=0x3C (hit) → mem_req/mem_we high with mem_addr=0x05, mem_wdata=0x3C until ack. A following MemRead 0x05 hits and returns 0x3C. MemWrite 0x0D (miss) then MemRead 0x0D → read miss (no allocate).
- Conflict: fill 0x05, then MemRead 0x0D (same idx, different tag) → miss and refill. A subsequent MemRead 0x05 misses again; miss_cnt increments each time.
- MemRead and MemWrite both high → write path taken (mem_we=1); hit_cnt and miss_cnt unchanged.
- Reset asserted in RD_MISS, then mem_ack pulses → mem_req=0 after the reset edge, valid bits clear, a later read of the same addr misses. Separately, 300 read hits → hit_cnt=255.
